// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - issues a packed vector instruction lane by lane to a scalar ALU
module vec_alu_sequencer #(
    parameter int dataSize = 8,
    parameter int lanes    = 4,
    parameter int laneIdxW = $clog2(lanes)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [lanes*dataSize-1:0] in_vec_a,
    input  logic [lanes*dataSize-1:0] in_vec_b,
    output logic [2:0]                alu_op,
    output logic [dataSize-1:0]       alu_operand1,
    output logic [dataSize-1:0]       alu_operand2,
    input  logic [dataSize-1:0]       alu_result,
    input  logic                      alu_neg,
    input  logic                      alu_zero,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [lanes*dataSize-1:0] out_vec,
    output logic [lanes-1:0]          out_neg_mask,
    output logic                      out_zero,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [laneIdxW-1:0] last_lane = laneIdxW'(lanes - 1);

    state_t                    state;
    state_t                    state_next;
    logic [laneIdxW-1:0]       lane_cnt;
    logic [2:0]                op_q;
    logic [lanes*dataSize-1:0] vec_a_q;
    logic [lanes*dataSize-1:0] vec_b_q;
    logic                      zero_acc;
    logic [dataSize-1:0]       lane_a;
    logic [dataSize-1:0]       lane_b;

    assign lane_a = vec_a_q[lane_cnt*dataSize +: dataSize];
    assign lane_b = vec_b_q[lane_cnt*dataSize +: dataSize];

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/ALU drive; ALU inputs are zero outside RUN
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        alu_op       = 3'd0;
        alu_operand1 = '0;
        alu_operand2 = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                alu_op       = op_q;
                alu_operand1 = lane_a;
                alu_operand2 = lane_b;
                if (lane_cnt == last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Instruction latch and per-lane result capture; results persist after the out handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt     <= '0;
            op_q         <= 3'd0;
            vec_a_q      <= '0;
            vec_b_q      <= '0;
            zero_acc     <= 1'b0;
            out_vec      <= '0;
            out_neg_mask <= '0;
            out_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q         <= in_op;
                        vec_a_q      <= in_vec_a;
                        vec_b_q      <= in_vec_b;
                        lane_cnt     <= '0;
                        out_vec      <= '0;
                        out_neg_mask <= '0;
                        zero_acc     <= 1'b1;
                    end
                end
                RUN: begin
                    out_vec[lane_cnt*dataSize +: dataSize] <= alu_result;
                    out_neg_mask[lane_cnt]                 <= alu_neg;
                    zero_acc                               <= zero_acc & alu_zero;
                    if (lane_cnt == last_lane) begin
                        out_zero <= zero_acc & alu_zero;
                    end else begin
                        lane_cnt <= lane_cnt + laneIdxW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb/tb_vec_alu_sequencer.sv - self-checking bench for vec_alu_sequencer with a behavioural ALU
module tb_vec_alu_sequencer;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int VW = DW * LN;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [VW-1:0] in_vec_a;
    logic [VW-1:0] in_vec_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_operand1;
    logic [DW-1:0] alu_operand2;
    logic [DW-1:0] alu_result;
    logic          alu_neg;
    logic          alu_zero;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;
    logic [LN-1:0] out_neg_mask;
    logic          out_zero;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    vec_alu_sequencer #(.dataSize(DW), .lanes(LN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_vec_a     (in_vec_a),
        .in_vec_b     (in_vec_b),
        .alu_op       (alu_op),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_result   (alu_result),
        .alu_neg      (alu_neg),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vec      (out_vec),
        .out_neg_mask (out_neg_mask),
        .out_zero     (out_zero),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in scalar ALU: {neg, zero, result}; add/sub flag the sign of the exact signed result
    function automatic logic [DW+1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]        r;
        logic signed [DW:0]   s;
        logic                 n;
        int                   sh;
        sh = int'(b[2:0]);
        s  = '0;
        case (op)
            3'd1:    r = a & b;
            3'd2:    begin s = $signed({a[DW-1], a}) + $signed({b[DW-1], b}); r = s[DW-1:0]; end
            3'd3:    begin s = $signed({a[DW-1], a}) - $signed({b[DW-1], b}); r = s[DW-1:0]; end
            3'd4:    r = a | b;
            3'd5:    r = DW'((a >> sh) | (a << (DW - sh)));
            3'd6:    r = DW'((a << sh) | (a >> (DW - sh)));
            3'd7:    r = a ^ b;
            default: r = '0;
        endcase
        n = (op == 3'd2 || op == 3'd3) ? s[DW] : r[DW-1];
        return {n, (r == '0), r};
    endfunction

    logic [DW+1:0] alu_out;
    always_comb alu_out = alu_fn(alu_op, alu_operand1, alu_operand2);
    assign alu_result = alu_out[DW-1:0];
    assign alu_zero   = alu_out[DW];
    assign alu_neg    = alu_out[DW+1];

    // Reference: whole-vector lane-wise evaluation of one instruction
    task automatic model(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         output logic [VW-1:0] ev, output logic [LN-1:0] en, output logic ez);
        logic [DW+1:0] r;
        ev = '0;
        en = '0;
        ez = 1'b1;
        for (int i = 0; i < LN; i++) begin
            r = alu_fn(op, a[i*DW +: DW], b[i*DW +: DW]);
            ev[i*DW +: DW] = r[DW-1:0];
            en[i] = r[DW+1];
            ez = ez & r[DW];
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 20 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Issue one instruction, watch each lane's ALU drive, then take the result
    task automatic do_vec(input string tag, input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [VW-1:0] ev, input logic [LN-1:0] en, input logic ez);
        wait_ready(tag);
        in_op = op; in_vec_a = a; in_vec_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); in_vec_a = $urandom; in_vec_b = $urandom;
        for (int i = 0; i < LN; i++) begin
            @(negedge clk);
            check({tag, " alu_op"}, 64'(alu_op), 64'(op));
            check({tag, " operand1"}, 64'(alu_operand1), 64'(a[i*DW +: DW]));
            check({tag, " operand2"}, 64'(alu_operand2), 64'(b[i*DW +: DW]));
            check({tag, " run out_valid"}, 64'({out_valid, in_ready, busy}), 64'b001);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " out_vec"}, 64'(out_vec), 64'(ev));
        check({tag, " out_neg_mask"}, 64'(out_neg_mask), 64'(en));
        check({tag, " out_zero"}, 64'(out_zero), 64'(ez));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " after handshake"}, 64'({out_valid, in_ready, busy}), 64'b010);
        check({tag, " out_vec held"}, 64'(out_vec), 64'(ev));
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] ev;
        logic [LN-1:0] en;
        logic          ez;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [2:0]    rop;
        logic [VW-1:0] ra, rb, rv, first_vec;
        logic [LN-1:0] rn, first_neg;
        logic          rz, first_zero;

        tbl[0] = '{3'd2, 32'h04030201, 32'h281E140A, 32'h2C21160B, 4'b0000, 1'b0};
        tbl[1] = '{3'd3, 32'h05050505, 32'h05050505, 32'h00000000, 4'b0000, 1'b1};
        tbl[2] = '{3'd3, 32'h03800901, 32'h03010102, 32'h007F08FF, 4'b0101, 1'b0};
        tbl[3] = '{3'd5, 32'h00000081, 32'h00000001, 32'h000000C0, 4'b0001, 1'b0};
        tbl[4] = '{3'd6, 32'h00000081, 32'h00000001, 32'h00000003, 4'b0000, 1'b0};
        tbl[5] = '{3'd0, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 4'b0000, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_vec_a = '0; in_vec_b = '0;
        #12;
        check("reset handshake", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset alu drive", 64'({alu_op, alu_operand1, alu_operand2}), 64'd0);
        check("reset results", 64'({out_vec, out_neg_mask, out_zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++)
            do_vec($sformatf("vec%0d", t), tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].ev, tbl[t].en, tbl[t].ez);

        for (int t = 0; t < 25; t++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (t % 5 == 0) ? ra : $urandom;
            model(rop, ra, rb, rv, rn, rz);
            do_vec($sformatf("rand%0d", t), rop, ra, rb, rv, rn, rz);
        end

        // Backpressure: results frozen in DONE and a stray in_valid is not taken
        wait_ready("bp");
        in_op = tbl[0].op; in_vec_a = tbl[0].a; in_vec_b = tbl[0].b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("bp reach done", 64'(out_valid), 64'd1);
        first_vec = out_vec; first_neg = out_neg_mask; first_zero = out_zero;
        check("bp vec", 64'(first_vec), 64'(tbl[0].ev));
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                in_valid = 1'b1; in_op = 3'd7; in_vec_a = $urandom; in_vec_b = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp stall status", 64'({out_valid, in_ready, busy}), 64'b101);
            check("bp stall vec", 64'(out_vec), 64'(tbl[0].ev));
            check("bp stall flags", 64'({out_neg_mask, out_zero}), 64'({tbl[0].en, tbl[0].ez}));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release", 64'({out_valid, in_ready, busy}), 64'b010);
        in_op = tbl[2].op; in_vec_a = tbl[2].a; in_vec_b = tbl[2].b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next accepted", 64'({in_ready, busy}), 64'b01);
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("bp next vec", 64'({out_valid, out_vec}), 64'({1'b1, tbl[2].ev}));
        check("bp next flags", 64'({out_neg_mask, out_zero}), 64'({tbl[2].en, tbl[2].ez}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset after lane 1 is captured clears outputs without a clock
        wait_ready("rst");
        in_op = 3'd2; in_vec_a = 32'h7F7F7F7F; in_vec_b = 32'h01010101; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async reset status", 64'({out_valid, in_ready, busy}), 64'b010);
        check("async reset vec", 64'(out_vec), 64'd0);
        check("async reset alu", 64'({alu_op, alu_operand1, alu_operand2}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_vec("post reset", tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].ev, tbl[0].en, tbl[0].ez);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
- Execute-stage controller that drives the scalar ALU from the other side of its interface.
- Accepts one vector instruction (3-bit operation code plus two packed operand vectors) over a valid/ready handshake.
- Issues one lane per cycle to the ALU and collects each lane's result and flags into a result buffer.
- Presents the finished vector and aggregate flags to the writeback stage over a second valid/ready handshake.

Parameters:
- dataSize, 8, lane width in bits; must match the connected ALU.
- lanes, 4, lanes per vector; must be ≥ 2.
- laneIdxW, $clog2(lanes), width of the internal lane counter (derived).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  sequencer can accept an instruction
- in_op  input  3  ALU operation code, passed unmodified to the ALU
- in_vec_a  input  lanes*dataSize  operand vector A; lane i = bits [i*dataSize +: dataSize], lane 0 at LSBs
- in_vec_b  input  lanes*dataSize  operand vector B, same packing
- alu_op  output  3  to ALU operation_select
- alu_operand1  output  dataSize  to ALU operand1
- alu_operand2  output  dataSize  to ALU operand2
- alu_result  input  dataSize  from ALU result (combinational)
- alu_neg  input  1  from ALU neg_flag
- alu_zero  input  1  from ALU zero_flag
- out_valid  output  1  result vector valid
- out_ready  input  1  downstream accepts result
- out_vec  output  lanes*dataSize  result vector, same packing as inputs
- out_neg_mask  output  lanes  bit i = ALU neg flag of lane i
- out_zero  output  1  1 when every lane's ALU zero flag was 1
- busy  output  1  1 in RUN or DONE

Behaviour:
- Reset (async, any state, including mid-instruction):
  - Go to IDLE and discard any in-flight instruction.
  - Outputs: in_ready=1, out_valid=0, busy=0, alu_op=0, alu_operand1=0, alu_operand2=0, out_vec=0, out_neg_mask=0, out_zero=0.
  - Internal: lane counter=0, latched op and vectors=0.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; alu_op and ALU operands driven 0.
  - On a clock edge with in_valid=1: latch in_op, in_vec_a and in_vec_b; clear the lane counter, out_neg_mask and out_vec; set an internal all-zero accumulator to 1; go to RUN.
- RUN:
  - in_ready=0.
  - alu_op = latched op; alu_operand1/alu_operand2 = latched lane[counter] of A/B.
  - Each edge:
    - write alu_result into out_vec lane[counter];
    - write alu_neg into out_neg_mask[counter];
    - AND alu_zero into the accumulator;
    - increment the counter.
  - On the edge where counter == lanes-1, go to DONE instead of incrementing; out_zero takes the final accumulator value on that edge.
- DONE:
  - out_valid=1; alu_op and operands driven 0; in_ready=0.
  - out_vec, out_neg_mask and out_zero are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE. out_valid drops; out_vec and the flags keep their values until the next accept.
- Timing:
  - Latency from the accept edge to out_valid high is lanes edges.
  - Minimum issue interval is lanes+2 cycles; there is no accept in the same cycle as an out handshake.
- Op code 000 is not special-cased: the sequencer iterates all lanes and captures whatever the ALU returns (0 from the team ALU, so out_zero=1).
- Upstream inputs are sampled only at the accept edge; later changes to in_* during RUN or DONE have no effect.
- Arithmetic and flag semantics are entirely the ALU's; the sequencer does no width extension or saturation.

Test Plan:
- Add, lanes=4: op=010, A lanes {1,2,3,4}, B lanes {10,20,30,40} → after 4 edges out_valid=1, out_vec lanes {11,22,33,44}, out_zero=0, out_neg_mask=0000; ALU operands observed lane 0..3 in consecutive cycles.
- All-zero sub: op=011, A=B={5,5,5,5} → out_vec=0, out_zero=1, out_neg_mask=0000.
- Neg mask: op=011, A={1,9,0x80,3}, B={2,1,1,3} → lanes {0xFF,0x08,0x7F,0x00}, out_neg_mask=0101 (lane0 and lane2 set), out_zero=0.
- Rotate: op=101, A lane0=0x81, B lane0=1 → out lane0=0xC0. Then op=110 with the same data → out lane0=0x03.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, out_vec and flags stable, in_ready=0, and a second in_valid pulse is ignored. Raise out_ready → IDLE next edge, in_ready=1. The next instruction is accepted on the following edge.
- Reset mid-RUN: assert rst_n=0 after lane 1 is captured → out_valid=0, in_ready=1, out_vec=0 immediately, with no clock needed. After release, a fresh add instruction completes correctly.
